// File: rtl/div_iter_ctrl_mvp_pkg.sv
// Shared definitions for the radix-2 non-restoring mantissa divider.
// State encodings are plain constants so the FSM stays legacy-tool friendly.
package div_iter_ctrl_mvp_pkg;

  localparam int unsigned DIV_WIDTH = 25;
  localparam int unsigned Q_BITS    = DIV_WIDTH + 2;
  localparam int unsigned CNT_W     = $clog2(Q_BITS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_HOLD = 2'd3;

endpackage

// File: rtl/nr_div_step_mvp.sv
// One non-restoring iteration: add or subtract the divisor depending on the
// sign of the partial remainder, emit the quotient bit and the doubled result.
module nr_div_step_mvp #(
  parameter int unsigned RW = 28,
  parameter int unsigned BW = 25
) (
  input  logic signed [RW-1:0] r_i,
  input  logic        [BW-1:0] b_i,
  output logic signed [RW-1:0] t_o,
  output logic                 q_o,
  output logic signed [RW-1:0] t2_o
);

  logic signed [RW-1:0] b_ext;

  assign b_ext = {{(RW-BW){1'b0}}, b_i};
  assign t_o   = r_i[RW-1] ? (r_i + b_ext) : (r_i - b_ext);
  assign q_o   = ~t_o[RW-1];
  assign t2_o  = {t_o[RW-2:0], 1'b0};

endmodule

// File: rtl/div_iter_ctrl_mvp.sv
// Sequential mantissa divider: one quotient bit per cycle, remainder fix-up
// for the sticky bit, then a valid/ready hold until downstream takes it.
//
// state | meaning
// IDLE  | ready for a new operation
// ITER  | producing one quotient bit per cycle
// FIX   | restore the final remainder, compute sticky
// HOLD  | result valid, waiting for Out_ready_SI
module div_iter_ctrl_mvp
  import div_iter_ctrl_mvp_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               Start_SI,
  input  logic               Kill_SI,
  input  logic [WIDTH-1:0]   Dividend_DI,
  input  logic [WIDTH-1:0]   Divisor_DI,
  output logic               Ready_SO,
  output logic               Out_valid_SO,
  input  logic               Out_ready_SI,
  output logic [WIDTH+1:0]   Quotient_DO,
  output logic               Sticky_DO
);

  localparam int unsigned QB = WIDTH + 2;
  localparam int unsigned RW = WIDTH + 3;
  localparam int unsigned CW = $clog2(QB);
  localparam logic [CW-1:0] CNT_LAST = CW'(QB - 1);

  state_t               state_q, state_d;
  logic signed [RW-1:0] rem_q, rem_d;
  logic signed [RW-1:0] last_t_q, last_t_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [QB-1:0]        quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;

  logic signed [RW-1:0] step_t, step_t2, div_ext, fix_rem;
  logic                 step_bit;

  nr_div_step_mvp #(
    .RW (RW),
    .BW (WIDTH)
  ) u_step (
    .r_i  (rem_q),
    .b_i  (div_q),
    .t_o  (step_t),
    .q_o  (step_bit),
    .t2_o (step_t2)
  );

  assign div_ext = {{(RW-WIDTH){1'b0}}, div_q};
  assign fix_rem = last_t_q[RW-1] ? (last_t_q + div_ext) : last_t_q;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    last_t_d = last_t_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_SI && !Kill_SI) begin
          rem_d   = {{(RW-WIDTH){1'b0}}, Dividend_DI};
          div_d   = Divisor_DI;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        rem_d    = step_t2;
        last_t_d = step_t;
        quo_d    = {quo_q[QB-2:0], step_bit};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        sticky_d = (fix_rem != '0);
        state_d  = ST_HOLD;
      end
      default: begin
        if (Out_ready_SI) state_d = ST_IDLE;
      end
    endcase
    // Kill only redirects control; the datapath keeps whatever it holds.
    if (Kill_SI) state_d = ST_IDLE;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      last_t_q <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      last_t_q <= last_t_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign Ready_SO     = (state_q == ST_IDLE);
  assign Out_valid_SO = (state_q == ST_HOLD);
  assign Quotient_DO  = quo_q;
  assign Sticky_DO    = sticky_q;

endmodule

// File: tb/tb_div_iter_ctrl_mvp.sv
// Directed bench for div_iter_ctrl_mvp with a scoreboard of expected results
// computed from exact integer division of the mantissas.
module tb_div_iter_ctrl_mvp;
  import div_iter_ctrl_mvp_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [W-1:0]    a_in = '0;
  logic [W-1:0]    b_in = '0;
  logic            ready;
  logic            valid;
  logic            out_ready = 1'b0;
  logic [W+1:0]    quo;
  logic            sticky;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_iter_ctrl_mvp #(.WIDTH(W)) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Start_SI     (start),
    .Kill_SI      (kill),
    .Dividend_DI  (a_in),
    .Divisor_DI   (b_in),
    .Ready_SO     (ready),
    .Out_valid_SO (valid),
    .Out_ready_SI (out_ready),
    .Quotient_DO  (quo),
    .Sticky_DO    (sticky)
  );

  // Quotient carries WIDTH+1 fraction bits: floor(A * 2^(W+1) / B).
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned num, q, r;
    num = longint'(a) << (W + 1);
    q   = num / longint'(b);
    r   = num % longint'(b);
    return {35'd0, (r != 0), q[W+1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    check("ready_timeout", 64'(n >= 100), 64'd0);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (push) exp_q.push_back(model(a, b));
  endtask

  task automatic wait_result(input bit check_lat, input int hold_cycles);
    int n;
    logic [63:0] e;
    n = 0;
    while (!valid && n < 100) begin tick(); n++; end
    check("valid_timeout", 64'(n >= 100), 64'd0);
    // Valid observed after Q_BITS+1 edges following accept, i.e. in cycle Q_BITS+2.
    if (check_lat) check("latency", 64'(n), 64'(Q_BITS + 1));
    check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("quotient", 64'(quo), {37'd0, e[26:0]});
      check("sticky", 64'(sticky), 64'(e[27]));
      for (int i = 0; i < hold_cycles; i++) begin
        start = 1'b1;
        a_in  = W'($urandom) | (W'(1) << (W - 1));
        b_in  = W'($urandom) | (W'(1) << (W - 1));
        tick();
        check("hold_state", {59'd0, valid, ready, sticky, 2'b00}, {59'd0, 1'b1, 1'b0, e[27], 2'b00});
        check("hold_quotient", 64'(quo), {37'd0, e[26:0]});
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_idle", {62'd0, ready, valid}, {62'd0, 1'b1, 1'b0});
  endtask

  initial begin
    bit seen;
    logic [W-1:0] ra, rb;

    #3;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_quo", 64'(quo), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    start_op(25'h1000000, 25'h1000000, 1'b1);
    wait_result(1'b1, 0);

    start_op(25'h1000000, 25'h1800000, 1'b1);
    wait_result(1'b1, 10);
    start_op(25'h1FFFFFF, 25'h1000000, 1'b1);
    wait_result(1'b1, 0);

    for (int k = 0; k < 3; k++) begin
      ra = W'($urandom) | (W'(1) << (W - 1));
      rb = W'($urandom) | (W'(1) << (W - 1));
      start_op(ra, rb, 1'b1);
      wait_result(1'b0, 0);
    end

    // Kill in the twelfth ITER cycle; nothing pushed, so a stray result mismatches.
    start_op(25'h1555555, 25'h1000001, 1'b0);
    repeat (11) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_idle", {62'd0, ready, valid}, {62'd0, 1'b1, 1'b0});
    start_op(25'h1000000, 25'h1000000, 1'b1);
    wait_result(1'b1, 0);

    // Leave sticky=1 behind so the async reset has something to clear.
    start_op(25'h1000000, 25'h1800000, 1'b1);
    wait_result(1'b0, 0);
    start_op(25'h1000000, 25'h1000000, 1'b0);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", {62'd0, ready, valid}, {62'd0, 1'b1, 1'b0});
    check("async_rst_quo", 64'(quo), 64'd0);
    check("async_rst_sticky", 64'(sticky), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    a_in  = 25'h1000000;
    b_in  = 25'h1000000;
    start = 1'b1;
    kill  = 1'b1;
    tick();
    start = 1'b0;
    kill  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (!ready || valid) seen = 1'b1;
      tick();
    end
    check("kill_start_no_op", 64'(seen), 64'd0);

    start_op(25'h1FFFFFF, 25'h1000000, 1'b1);
    wait_result(1'b1, 0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
